demux_l1: RTL and testbench

Receive-side first demultiplexing layer of the PHY, at the other end of the L1 multiplexer. It takes two 8-bit lanes, each carrying time-interleaved bytes at the clk_2f rate, and splits each lane into two byte streams (four outputs). Each output updates once every two clk_2f cycles, with its own valid flag. It sits between the lane deserializer (upstream) and the L0 demux stage that restores the clk_f-rate channels (downstream).

---
 rtl/demux_l1_pkg.sv | 20 ++
 rtl/demux_l1_if.sv | 30 +++
 rtl/demux_l1_demux1x2.sv | 64 ++++++
 rtl/demux_l1.sv | 33 +++
 tb/tb_demux_l1.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/demux_l1_pkg.sv
// rtl/demux_l1_pkg.sv - shared widths, lane counts and slot phase type for demux_l1
package demux_l1_pkg;

    localparam int BUS_W     = 8;
    localparam int LANES_IN  = 2;
    localparam int LANES_OUT = 4;

    localparam logic PHASE_EVEN = 1'b0;
    localparam logic PHASE_ODD  = 1'b1;

    typedef enum logic {
        PH_EVEN = PHASE_EVEN,
        PH_ODD  = PHASE_ODD
    } phase_e;

    function automatic phase_e next_phase(input phase_e p);
        return (p == PH_EVEN) ? PH_ODD : PH_EVEN;
    endfunction

endpackage

// File: rtl/demux_l1_if.sv
// rtl/demux_l1_if.sv - lane inputs and demultiplexed outputs of demux_l1
interface demux_l1_if;
    import demux_l1_pkg::*;

    logic [BUS_W-1:0] Entrada0;
    logic [BUS_W-1:0] Entrada1;
    logic             validEntrada0;
    logic             validEntrada1;
    logic [BUS_W-1:0] Salida0;
    logic [BUS_W-1:0] Salida1;
    logic [BUS_W-1:0] Salida2;
    logic [BUS_W-1:0] Salida3;
    logic             validsalida0;
    logic             validsalida1;
    logic             validsalida2;
    logic             validsalida3;

    modport master (
        output Entrada0, Entrada1, validEntrada0, validEntrada1,
        input  Salida0, Salida1, Salida2, Salida3,
        input  validsalida0, validsalida1, validsalida2, validsalida3
    );

    modport slave (
        input  Entrada0, Entrada1, validEntrada0, validEntrada1,
        output Salida0, Salida1, Salida2, Salida3,
        output validsalida0, validsalida1, validsalida2, validsalida3
    );

endinterface

// File: rtl/demux_l1_demux1x2.sv
// rtl/demux_l1_demux1x2.sv - one interleaved lane split into even/odd byte outputs
// DEMUXL1_ZERO_INVALID_EN: invalid slots write 0x00 instead of holding the old byte.
module demux1x2
    import demux_l1_pkg::*;
(
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [BUS_W-1:0] lane_d,
    input  logic             lane_v,
    output logic [BUS_W-1:0] even_d,
    output logic             even_v,
    output logic [BUS_W-1:0] odd_d,
    output logic             odd_v
);

    phase_e           phase_q;
    phase_e           phase_d;
    logic [BUS_W-1:0] hold_d;
    logic             hold_v;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            phase_q <= PH_EVEN;
        end else begin
            phase_q <= phase_d;
        end
    end

    // The phase free-runs regardless of valid; every slot is consumed.
    always_comb begin
        phase_d = PH_EVEN;
        phase_d = next_phase(phase_q);
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            hold_d <= '0;
            hold_v <= 1'b0;
            even_d <= '0;
            even_v <= 1'b0;
            odd_d  <= '0;
            odd_v  <= 1'b0;
        end else if (phase_q == PH_EVEN) begin
            hold_d <= lane_d;
            hold_v <= lane_v;
        end else begin
            // Both outputs of the lane change together on the odd edge.
            even_v <= hold_v;
            odd_v  <= lane_v;
`ifdef DEMUXL1_ZERO_INVALID_EN
            even_d <= hold_v ? hold_d : '0;
            odd_d  <= lane_v ? lane_d : '0;
`else
            if (hold_v) begin
                even_d <= hold_d;
            end
            if (lane_v) begin
                odd_d <= lane_d;
            end
`endif
        end
    end

endmodule

// File: rtl/demux_l1.sv
// rtl/demux_l1.sv - receive-side L1 demux: two interleaved lanes to four byte streams
// DEMUXL1_ZERO_INVALID_EN selects zeroing of invalid slots inside demux1x2.
module demux_l1
    import demux_l1_pkg::*;
(
    input  logic       clk_2f,
    input  logic       reset,
    demux_l1_if.slave  bus
);

    demux1x2 u_lane0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .lane_d (bus.Entrada0),
        .lane_v (bus.validEntrada0),
        .even_d (bus.Salida0),
        .even_v (bus.validsalida0),
        .odd_d  (bus.Salida1),
        .odd_v  (bus.validsalida1)
    );

    demux1x2 u_lane1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .lane_d (bus.Entrada1),
        .lane_v (bus.validEntrada1),
        .even_d (bus.Salida2),
        .even_v (bus.validsalida2),
        .odd_d  (bus.Salida3),
        .odd_v  (bus.validsalida3)
    );

endmodule

// File: tb/tb_demux_l1.sv
// tb/tb_demux_l1.sv - scoreboard bench for demux_l1 (honours DEMUXL1_ZERO_INVALID_EN)
module tb_demux_l1;
    import demux_l1_pkg::*;

`ifdef DEMUXL1_ZERO_INVALID_EN
    localparam bit ZERO_INV = 1'b1;
`else
    localparam bit ZERO_INV = 1'b0;
`endif

    typedef struct packed {
        logic [LANES_OUT-1:0][7:0] d;
        logic [LANES_OUT-1:0]      v;
    } exp_t;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    exp_t                      sb_q[$];
    logic [LANES_OUT-1:0][7:0] cur_d = '0;
    logic [LANES_OUT-1:0]      cur_v = '0;

    demux_l1_if bus ();

    demux_l1 dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic sample(output logic [LANES_OUT-1:0][7:0] d, output logic [LANES_OUT-1:0] v);
        d = {bus.Salida3, bus.Salida2, bus.Salida1, bus.Salida0};
        v = {bus.validsalida3, bus.validsalida2, bus.validsalida1, bus.validsalida0};
    endtask

    // One even+odd slot pair on both lanes; checks hold on the even edge and update on the odd edge.
    task automatic drive_pair(input string name,
                              input logic [7:0] e0, input logic ev0, input logic [7:0] o0, input logic ov0,
                              input logic [7:0] e1, input logic ev1, input logic [7:0] o1, input logic ov1);
        logic [LANES_OUT-1:0][7:0] b;
        logic [LANES_OUT-1:0][7:0] gd;
        logic [LANES_OUT-1:0]      gv;
        logic [LANES_OUT-1:0][7:0] prev_d;
        logic [LANES_OUT-1:0]      prev_v;
        exp_t                      e;
        exp_t                      want;
        b      = {o1, e1, o0, e0};
        e.v    = {ov1, ev1, ov0, ev0};
        prev_d = cur_d;
        prev_v = cur_v;
        for (int i = 0; i < LANES_OUT; i++)
            e.d[i] = e.v[i] ? b[i] : (ZERO_INV ? 8'h00 : cur_d[i]);
        cur_d = e.d;
        cur_v = e.v;
        sb_q.push_back(e);

        bus.Entrada0 = e0; bus.validEntrada0 = ev0;
        bus.Entrada1 = e1; bus.validEntrada1 = ev1;
        tick();
        sample(gd, gv);
        for (int i = 0; i < LANES_OUT; i++) begin
            checks++;
            if (gd[i] !== prev_d[i] || gv[i] !== prev_v[i]) begin
                errors++;
                $display("FAIL %s hold Salida%0d: got %h/%b want %h/%b", name, i, gd[i], gv[i], prev_d[i], prev_v[i]);
            end
        end

        bus.Entrada0 = o0; bus.validEntrada0 = ov0;
        bus.Entrada1 = o1; bus.validEntrada1 = ov1;
        tick();
        sample(gd, gv);
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue want 1 entry", name);
        end else begin
            want = sb_q.pop_front();
            for (int i = 0; i < LANES_OUT; i++) begin
                checks++;
                if (gd[i] !== want.d[i]) begin
                    errors++;
                    $display("FAIL %s Salida%0d: got %h want %h", name, i, gd[i], want.d[i]);
                end
                checks++;
                if (gv[i] !== want.v[i]) begin
                    errors++;
                    $display("FAIL %s validsalida%0d: got %b want %b", name, i, gv[i], want.v[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [LANES_OUT-1:0][7:0] gd;
        logic [LANES_OUT-1:0]      gv;
        reset = 1'b1;
        bus.Entrada0 = 8'hFF; bus.validEntrada0 = 1'b1;
        bus.Entrada1 = 8'hFF; bus.validEntrada1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            sample(gd, gv);
            checks++;
            if (gd !== '0 || gv !== '0) begin
                errors++;
                $display("FAIL reset edge%0d: got %h/%b want 0/0", k, gd, gv);
            end
        end
        reset = 1'b0;
        cur_d = '0;
        cur_v = '0;
    endtask

    task automatic test_first_pair();
        drive_pair("first_pair", 8'hA1, 1'b1, 8'hB2, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_full_rate();
        drive_pair("full_rate_a", 8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 1'b1, 8'h11, 1'b1);
        drive_pair("full_rate_b", 8'h00, 1'b0, 8'h00, 1'b0, 8'h12, 1'b1, 8'h13, 1'b1);
    endtask

    task automatic test_invalid_odd();
        drive_pair("inv_odd_pre", 8'h11, 1'b1, 8'h22, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        drive_pair("inv_odd",     8'h55, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_lane_independence();
        drive_pair("lane_indep_pre", 8'h00, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b1, 8'hA5, 1'b1);
        drive_pair("lane_indep",     8'h01, 1'b1, 8'h02, 1'b1, 8'hEE, 1'b0, 8'hEF, 1'b0);
    endtask

    task automatic test_mid_reset();
        logic [LANES_OUT-1:0][7:0] gd;
        logic [LANES_OUT-1:0]      gv;
        bus.Entrada0 = 8'h77; bus.validEntrada0 = 1'b1;
        bus.Entrada1 = 8'h78; bus.validEntrada1 = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        sample(gd, gv);
        checks++;
        if (gd !== '0 || gv !== '0) begin
            errors++;
            $display("FAIL mid_reset async: got %h/%b want 0/0", gd, gv);
        end
        tick();
        reset = 1'b0;
        cur_d = '0;
        cur_v = '0;
        sb_q.delete();
        drive_pair("after_mid_reset", 8'h33, 1'b1, 8'h44, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_round_trip();
        logic [7:0] s0, s1, s2, s3;
        for (int n = 0; n < 250; n++) begin
            s0 = 8'($urandom_range(0, 255));
            s1 = 8'($urandom_range(0, 255));
            s2 = 8'($urandom_range(0, 255));
            s3 = 8'($urandom_range(0, 255));
            drive_pair("round_trip", s0, 1'b1, s1, 1'b1, s2, 1'b1, s3, 1'b1);
        end
    endtask

    initial begin
        bus.Entrada0 = 8'h00; bus.validEntrada0 = 1'b0;
        bus.Entrada1 = 8'h00; bus.validEntrada1 = 1'b0;
        test_reset();
        test_first_pair();
        test_full_rate();
        test_invalid_odd();
        test_lane_independence();
        test_mid_reset();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
